// File: rtl/obstacle_scheduler_pkg.sv
// Shared obstacle definitions: scheduler state encoding, obstacle count and index helpers.
package obstacle_scheduler_pkg;

    localparam int         OBSTACLE_COUNT = 6;
    localparam logic [2:0] SELECT_BLANK   = 3'd0;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PICK,
        ST_START,
        ST_RUN,
        ST_GAP
    } state_t;

    // Index 0 is the blank screen and yields an all-zero vector.
    function automatic logic [OBSTACLE_COUNT-1:0] idxOneHot(input logic [2:0] idx);
        logic [OBSTACLE_COUNT-1:0] v;
        v = '0;
        for (int k = 1; k <= OBSTACLE_COUNT; k++) begin
            v[k-1] = (idx == 3'(k));
        end
        return v;
    endfunction

    // Random bits 0..5 map to 1..6, 6/7 fold onto 1/2; a repeat of the last obstacle is bumped by one.
    function automatic logic [2:0] pickIndex(input logic [2:0] bits, input logic [2:0] prev);
        logic [2:0] idx;
        idx = (bits >= 3'd6) ? (bits - 3'd5) : (bits + 3'd1);
        if (idx == prev) begin
            idx = (idx == 3'd6) ? 3'd1 : (idx + 3'd1);
        end
        return idx;
    endfunction

endpackage

// File: rtl/obstacle_scheduler_lfsr8.sv
// Free-running 8-bit Fibonacci LFSR, taps for x^8+x^6+x^5+x^4+1.
module lfsr8 (
    input  logic       pclk,
    input  logic       rst,
    input  logic [7:0] seed,
    output logic [7:0] out
);

    logic [7:0] r_lfsr;
    logic       w_feedback;

    assign w_feedback = r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3];

    // An all-zero seed would lock the register, so it is replaced by 1.
    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            r_lfsr <= (seed == 8'h00) ? 8'h01 : seed;
        end else begin
            r_lfsr <= {r_lfsr[6:0], w_feedback};
        end
    end

    assign out = r_lfsr;

endmodule

// File: rtl/obstacle_scheduler.sv
// Picks a pseudo-random obstacle each round, runs it until done or timeout, then blanks for a gap.
module obstacle_scheduler
    import obstacle_scheduler_pkg::*;
#(
    parameter int         GAP_FRAMES     = 60,
    parameter int         TIMEOUT_FRAMES = 600,
    parameter logic [7:0] LFSR_SEED      = 8'hA5
) (
    input  logic                      pclk,
    input  logic                      rst,
    input  logic                      game_on,
    input  logic                      frame_tick,
    input  logic [OBSTACLE_COUNT-1:0] obstacle_done,
    output logic [2:0]                select,
    output logic [OBSTACLE_COUNT-1:0] obstacle_start,
    output logic                      busy,
    output logic                      timeout,
    output logic [7:0]                cleared_cnt
);

    localparam logic [15:0] GAP_LIM     = 16'(GAP_FRAMES);
    localparam logic [15:0] TIMEOUT_LIM = 16'(TIMEOUT_FRAMES);

    state_t                    r_state;
    state_t                    w_stateNext;
    logic [2:0]                r_idx;
    logic [2:0]                w_idxNext;
    logic [2:0]                r_prevIdx;
    logic [2:0]                w_prevNext;
    logic [15:0]               r_frameCnt;
    logic [15:0]               w_frameNext;
    logic [15:0]               w_frameInc;
    logic [7:0]                r_clearedCnt;
    logic [7:0]                w_clearedNext;
    logic [2:0]                r_select;
    logic [2:0]                w_selectNext;
    logic [OBSTACLE_COUNT-1:0] r_start;
    logic [OBSTACLE_COUNT-1:0] w_startNext;
    logic                      r_busy;
    logic                      w_busyNext;
    logic                      r_timeout;
    logic                      w_timeoutNext;
    logic [7:0]                w_lfsr;
    logic                      w_doneHit;
    logic                      w_unusedLfsr;

    lfsr8 u_lfsr (
        .pclk (pclk),
        .rst  (rst),
        .seed (LFSR_SEED),
        .out  (w_lfsr)
    );

    assign w_unusedLfsr = ^w_lfsr[7:3];
    assign w_frameInc   = r_frameCnt + 16'd1;
    assign w_doneHit    = |(obstacle_done & idxOneHot(r_idx));

    // Outputs are derived from the next state so they register in step with it.
    always_comb begin
        w_stateNext   = r_state;
        w_idxNext     = r_idx;
        w_prevNext    = r_prevIdx;
        w_frameNext   = r_frameCnt;
        w_clearedNext = r_clearedCnt;
        w_timeoutNext = 1'b0;

        if (!game_on && (r_state != ST_IDLE)) begin
            w_stateNext = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (game_on) begin
                        w_clearedNext = 8'd0;
                        w_prevNext    = SELECT_BLANK;
                        w_stateNext   = ST_PICK;
                    end
                end
                ST_PICK: begin
                    w_idxNext   = pickIndex(w_lfsr[2:0], r_prevIdx);
                    w_frameNext = 16'd0;
                    w_stateNext = ST_START;
                end
                ST_START: begin
                    w_frameNext = 16'd0;
                    w_stateNext = ST_RUN;
                end
                ST_RUN: begin
                    if (w_doneHit) begin
                        w_clearedNext = (r_clearedCnt == 8'hFF) ? r_clearedCnt : (r_clearedCnt + 8'd1);
                        w_frameNext   = 16'd0;
                        w_stateNext   = ST_GAP;
                    end else if (frame_tick) begin
                        if (w_frameInc == TIMEOUT_LIM) begin
                            w_timeoutNext = 1'b1;
                            w_frameNext   = 16'd0;
                            w_stateNext   = ST_GAP;
                        end else begin
                            w_frameNext = w_frameInc;
                        end
                    end
                end
                ST_GAP: begin
                    w_prevNext = r_idx;
                    if (frame_tick) begin
                        if (w_frameInc == GAP_LIM) begin
                            w_frameNext = 16'd0;
                            w_stateNext = ST_PICK;
                        end else begin
                            w_frameNext = w_frameInc;
                        end
                    end
                end
                default: begin
                    w_stateNext = ST_IDLE;
                end
            endcase
        end

        w_busyNext   = (w_stateNext == ST_START) || (w_stateNext == ST_RUN);
        w_selectNext = w_busyNext ? w_idxNext : SELECT_BLANK;
        w_startNext  = (w_stateNext == ST_START) ? idxOneHot(w_idxNext) : '0;
    end

    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_idx        <= SELECT_BLANK;
            r_prevIdx    <= SELECT_BLANK;
            r_frameCnt   <= 16'd0;
            r_clearedCnt <= 8'd0;
            r_select     <= SELECT_BLANK;
            r_start      <= '0;
            r_busy       <= 1'b0;
            r_timeout    <= 1'b0;
        end else begin
            r_state      <= w_stateNext;
            r_idx        <= w_idxNext;
            r_prevIdx    <= w_prevNext;
            r_frameCnt   <= w_frameNext;
            r_clearedCnt <= w_clearedNext;
            r_select     <= w_selectNext;
            r_start      <= w_startNext;
            r_busy       <= w_busyNext;
            r_timeout    <= w_timeoutNext;
        end
    end

    assign select         = r_select;
    assign obstacle_start = r_start;
    assign busy           = r_busy;
    assign timeout        = r_timeout;
    assign cleared_cnt    = r_clearedCnt;

endmodule
